// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational mini_alu between NUM_REQ requesters,
// returning tagged results on a single response channel and owning the icc flag register.
module alu_share_arbiter #(
  parameter int          NUM_REQ  = 2,
  parameter logic [3:0]  CC_RESET = 4'b0000,
  localparam int         ID_W     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*4-1:0]   req_op,
  input  logic [NUM_REQ-1:0]     req_setcc,
  input  logic [NUM_REQ-1:0]     req_usec,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic                   alu_cin,
  output logic [3:0]             alu_opcode,
  input  logic [31:0]            alu_y,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_y,
  output logic [3:0]             rsp_flags,
  output logic [3:0]             icc
);

  localparam int IDX_W = ID_W + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   last_grant_reg;
  logic [ID_W-1:0]   id_reg;
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;
  logic [3:0]        op_reg;
  logic              setcc_reg;
  logic              cin_reg;
  logic              rsp_valid_reg;
  logic [31:0]       rsp_y_reg;
  logic [3:0]        rsp_flags_reg;
  logic [3:0]        icc_reg;

  logic [31:0]       a_arr  [NUM_REQ];
  logic [31:0]       b_arr  [NUM_REQ];
  logic [3:0]        op_arr [NUM_REQ];

  logic [ID_W-1:0]   grant_next;
  logic              grant_found;
  logic [IDX_W-1:0]  idx;
  logic              accept;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[32*gi +: 32];
      assign b_arr[gi]  = req_b[32*gi +: 32];
      assign op_arr[gi] = req_op[4*gi +: 4];
    end
  endgenerate

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_next  = '0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, last_grant_reg} + IDX_W'(i) + IDX_W'(1);
      if (idx >= IDX_W'(NUM_REQ)) begin
        idx = idx - IDX_W'(NUM_REQ);
      end
      if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_next  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_reg == IDLE) && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_next;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      id_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      setcc_reg      <= 1'b0;
      cin_reg        <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_y_reg      <= '0;
      rsp_flags_reg  <= '0;
      icc_reg        <= CC_RESET;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg          <= a_arr[grant_next];
            b_reg          <= b_arr[grant_next];
            op_reg         <= op_arr[grant_next];
            setcc_reg      <= req_setcc[grant_next];
            // icc is settled in IDLE, so sampling it here equals the value seen during EXEC.
            cin_reg        <= req_usec[grant_next] & icc_reg[0];
            id_reg         <= grant_next;
            last_grant_reg <= grant_next;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_reg     <= alu_y;
          rsp_flags_reg <= alu_flags;
          if (setcc_reg) begin
            icc_reg <= alu_flags;
          end
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // ALU inputs come straight from the operand latches, so they stay put between operations.
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_cin    = cin_reg;
  assign alu_opcode = op_reg;

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = id_reg;
  assign rsp_y      = rsp_y_reg;
  assign rsp_flags  = rsp_flags_reg;
  assign icc        = icc_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: models the external mini_alu and scoreboards every response.
module tb_alu_share_arbiter;

  localparam int N   = 2;
  localparam int IDW = 1;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*4-1:0]  req_op;
  logic [N-1:0]    req_setcc;
  logic [N-1:0]    req_usec;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic            alu_cin;
  logic [3:0]      alu_opcode;
  logic [31:0]     alu_y;
  logic [3:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_y;
  logic [3:0]      rsp_flags;
  logic [3:0]      icc;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    y;
    logic [3:0]     f;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] icc_m;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .CC_RESET(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_setcc(req_setcc), .req_usec(req_usec),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .icc(icc)
  );

  // mini_alu model: returns {y, N, Z, V, C}
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] y;
    logic        v;
    logic        c;
    v = 1'b0;
    c = 1'b0;
    s = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        y = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        y = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      4'h2:    y = a & b;
      4'h3:    y = a | b;
      default: y = a ^ b;
    endcase
    return {y, y[31], (y == 32'h0), v, c};
  endfunction

  assign {alu_y, alu_flags} = alu_ref(alu_a, alu_b, alu_cin, alu_opcode);

  // Response scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d y=%h flags=%b, expected no response",
                 rsp_id, rsp_y, rsp_flags);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rsp_id, rsp_y, rsp_flags} !== {e.id, e.y, e.f}) begin
          bad++;
          $display("FAIL rsp_data: got id=%0d y=%h flags=%b, expected id=%0d y=%h flags=%b",
                   rsp_id, rsp_y, rsp_flags, e.id, e.y, e.f);
        end else begin
          $display("rsp id=%0d y=%h flags=%b ok", rsp_id, rsp_y, rsp_flags);
        end
      end
    end
  end

  task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic sc, input logic us);
    req_valid[r]      = 1'b1;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_op[4*r +: 4]  = op;
    req_setcc[r]      = sc;
    req_usec[r]       = us;
  endtask

  // Issues one op, waits (bounded) for its grant, and records the expected response.
  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic sc, input logic us, output int waited);
    logic [35:0] res;
    @(posedge clk); #1;
    drive_req(r, a, b, op, sc, us);
    waited = 0;
    @(negedge clk);
    while (!req_ready[r] && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!req_ready[r]) begin
      bad++;
      $display("FAIL grant_timeout: req%0d ready=%b after %0d cycles, required 1", r, req_ready, waited);
    end else begin
      res = alu_ref(a, b, us & icc_m[0], op);
      exp_q.push_back('{id: IDW'(r), y: res[35:4], f: res[3:0]});
      if (sc) icc_m = res[3:0];
      $display("issue req%0d a=%h b=%h op=%0d setcc=%0b usec=%0b wait=%0d", r, a, b, op, sc, us, waited);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic apply_reset(input logic [N-1:0] valids);
    rst_n     = 1'b0;
    req_valid = valids;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    icc_m = 4'b0000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a = '1; req_b = '1; req_op = '0; req_setcc = '1; req_usec = '1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_flags, icc} !== {1'b0, {IDW{1'b0}}, 32'h0, 4'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset_rsp: got valid=%b id=%0d y=%h flags=%b icc=%b, required all zero",
               rsp_valid, rsp_id, rsp_y, rsp_flags, icc);
    end
    total++;
    if ({req_ready, alu_a, alu_b, alu_cin, alu_opcode} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b alu_a=%h alu_b=%h cin=%b op=%h, required zero",
               req_ready, alu_a, alu_b, alu_cin, alu_opcode);
    end
    $display("reset state checked");
    req_valid = '0;
    apply_reset('0);
  endtask

  task automatic test_single();
    int w;
    send(0, 32'h00000001, 32'hBFFFFFFF, OP_ADD, 1'b1, 1'b0, w);
    total++;
    if (w !== 0) begin
      bad++;
      $display("FAIL single_ready_latency: got %0d cycles, required 0", w);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || alu_a !== 32'h1 || alu_b !== 32'hBFFFFFFF || alu_opcode !== OP_ADD) begin
      bad++;
      $display("FAIL single_exec: got rsp_valid=%b alu_a=%h alu_b=%h op=%h, required 0/00000001/bfffffff/0",
               rsp_valid, alu_a, alu_b, alu_opcode);
    end
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_flags, icc} !== {1'b1, 1'b0, 32'hC0000000, 4'b1000, 4'b1000}) begin
      bad++;
      $display("FAIL single_rsp: got valid=%b id=%0d y=%h flags=%b icc=%b, required 1/0/c0000000/1000/1000",
               rsp_valid, rsp_id, rsp_y, rsp_flags, icc);
    end
  endtask

  task automatic test_contention();
    int k;
    logic [35:0] res;
    logic [N-1:0] want;
    drain();
    rst_n = 1'b0;
    drive_req(0, 32'h5, 32'h7, OP_ADD, 1'b0, 1'b0);
    drive_req(1, 32'hFFFFFFFF, 32'h1, OP_SUB, 1'b1, 1'b0);
    apply_reset(2'b11);
    k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        want = (k % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== want || cyc != 3 * k) begin
          bad++;
          $display("FAIL contention_grant: got ready=%b at cycle %0d, required %b at cycle %0d",
                   req_ready, cyc, want, 3 * k);
        end
        if (k % 2 == 0) res = alu_ref(32'h5, 32'h7, 1'b0, OP_ADD);
        else            res = alu_ref(32'hFFFFFFFF, 32'h1, 1'b0, OP_SUB);
        exp_q.push_back('{id: IDW'(k % 2), y: res[35:4], f: res[3:0]});
        if (k % 2 == 1) icc_m = res[3:0];
        $display("grant %0d to req%0d at cycle %0d", k, k % 2, cyc);
        k++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    total++;
    if (k !== 4) begin
      bad++;
      $display("FAIL contention_count: got %0d grants, required 4", k);
    end
    drain();
    total++;
    if (icc !== icc_m) begin
      bad++;
      $display("FAIL contention_icc: got %b, required %b", icc, icc_m);
    end
  endtask

  task automatic test_carry_chain();
    int w;
    send(0, 32'h80000000, 32'h80000000, OP_ADD, 1'b1, 1'b0, w);
    send(1, 32'h0, 32'h0, OP_ADD, 1'b0, 1'b1, w);
    @(negedge clk);
    total++;
    if (alu_cin !== 1'b1) begin
      bad++;
      $display("FAIL carry_cin: got alu_cin=%b, required 1", alu_cin);
    end
    @(negedge clk);
    total++;
    if (rsp_y !== 32'h1 || icc !== 4'b0111) begin
      bad++;
      $display("FAIL carry_rsp: got y=%h icc=%b, required 00000001/0111", rsp_y, icc);
    end
  endtask

  task automatic test_backpressure();
    int w;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(0, 32'h12345678, 32'h1, OP_XOR, 1'b0, 1'b0, w);
    @(negedge clk);
    @(posedge clk); #1;
    drive_req(1, 32'h3, 32'h4, OP_ADD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_y !== 32'h12345679 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL backpressure_hold: cycle %0d got valid=%b y=%h id=%0d ready=%b, required 1/12345679/0/00",
                 i, rsp_valid, rsp_y, rsp_id, req_ready);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin
      bad++;
      $display("FAIL backpressure_bypass: got ready=%b in RESP, required 00", req_ready);
    end
    send(1, 32'h3, 32'h4, OP_ADD, 1'b0, 1'b0, w);
    total++;
    if (w !== 0) begin
      bad++;
      $display("FAIL backpressure_next_grant: got wait=%0d, required 0", w);
    end
    drain();
  endtask

  task automatic test_no_setcc();
    int w;
    send(0, 32'h40000000, 32'h40000000, OP_ADD, 1'b0, 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rsp_flags !== 4'b1010 || icc !== icc_m) begin
      bad++;
      $display("FAIL nosetcc: got flags=%b icc=%b, required 1010/%b", rsp_flags, icc, icc_m);
    end
  endtask

  task automatic test_reset_exec();
    int w;
    exp_t dropped;
    send(1, 32'h7FFFFFFF, 32'h1, OP_ADD, 1'b1, 1'b0, w);
    rst_n   = 1'b0;
    dropped = exp_q.pop_back();
    icc_m   = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || icc !== 4'b0000 || alu_a !== 32'h0 || req_ready !== 2'b00) begin
      bad++;
      $display("FAIL reset_exec: got valid=%b icc=%b alu_a=%h ready=%b, required 0/0000/0/00 (dropped y=%h)",
               rsp_valid, icc, alu_a, req_ready, dropped.y);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_exec_quiet: got rsp_valid=%b at cycle %0d, required 0", rsp_valid, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, N - 1)), $urandom, $urandom, 4'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
    end
    drain();
    total++;
    if (icc !== icc_m) begin
      bad++;
      $display("FAIL back_to_back_icc: got %b, required %b", icc, icc_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    req_setcc = '0; req_usec = '0; rsp_ready = 1'b1; rst_n = 1'b0;
    icc_m = 4'b0000;
    test_reset();
    test_single();
    test_contention();
    test_carry_chain();
    test_backpressure();
    test_no_setcc();
    test_reset_exec();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
